// File: rtl/concat_pingpong_buffer_if.sv
// -----------------------------------------------------------------------------
// concat_pingpong_buffer_if
// Bundles the word-input handshake and the block-output/release signals of the
// ping-pong concatenation buffer.
//   in_data   : input word (DATA_SIZE bits)
//   in_valid  : in_data is valid this cycle
//   in_last   : qualified by in_valid, closes the current block
//   in_ready  : buffer can accept a word this cycle
//   out_data  : flattened presented bank, entry i at [i*DATA_SIZE +: DATA_SIZE]
//   out_valid : out_data holds a closed block
//   out_count : number of valid entries in the presented block
//   out_ack   : consumer releases the presented block
//   full      : both banks closed, input stalled
// master = upstream producer plus downstream consumer, slave = the buffer.
// -----------------------------------------------------------------------------
interface concat_pingpong_buffer_if #(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_MATRICES = 2
);
  localparam int NO_REG = 64 * NUM_MATRICES;
  localparam int CNT_W  = $clog2(NO_REG + 1);

  logic [DATA_SIZE-1:0]        in_data;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic [DATA_SIZE*NO_REG-1:0] out_data;
  logic                        out_valid;
  logic [CNT_W-1:0]            out_count;
  logic                        out_ack;
  logic                        full;

  modport master (
    output in_data, in_valid, in_last, out_ack,
    input  in_ready, out_data, out_valid, out_count, full
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ack,
    output in_ready, out_data, out_valid, out_count, full
  );
endinterface

// File: rtl/concat_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// concat_pingpong_buffer
// Collects DATA_SIZE-bit words into NO_REG-entry blocks (one or more 64-word
// ChaCha20 state matrices). Two banks alternate: one fills from upstream while
// the other is presented to the consumer until it is acknowledged. A block
// closes when its last slot is written or when in_last accompanies a word.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus_io : slave side of concat_pingpong_buffer_if (handshake + block output)
// -----------------------------------------------------------------------------
module concat_pingpong_buffer #(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_MATRICES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  concat_pingpong_buffer_if.slave bus_io
);
  localparam int NO_REG = 64 * NUM_MATRICES;
  localparam int CNT_W  = $clog2(NO_REG + 1);
  localparam int PTR_W  = $clog2(NO_REG);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_state_e;

  bank_state_e                             state_q [0:1];
  bank_state_e                             state_d [0:1];
  logic [CNT_W-1:0]                        cnt_q   [0:1];
  logic [CNT_W-1:0]                        cnt_d   [0:1];
  logic                                    wr_bank_q, wr_bank_d;
  logic                                    rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d;
  logic                                    in_ready_q, in_ready_d;
  logic                                    out_valid_q, out_valid_d;
  logic                                    full_q, full_d;
  logic [CNT_W-1:0]                        out_count_q, out_count_d;
  logic [1:0][NO_REG-1:0][DATA_SIZE-1:0]   mem_q;

  logic accept_s;
  logic close_s;
  logic release_s;

  // Handshake qualifiers; in_ready_q is a flop so in_valid never reaches in_ready.
  assign accept_s  = bus_io.in_valid & in_ready_q;
  assign close_s   = accept_s & ((wr_ptr_q == PTR_W'(NO_REG - 1)) | bus_io.in_last);
  assign release_s = bus_io.out_ack & out_valid_q;

  // Next-state for bank FSMs, pointers, counts and registered status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;

    for (int b = 0; b < 2; b++) begin
      case (state_q[b])
        ST_EMPTY, ST_FILLING: begin
          if (accept_s && (wr_bank_q == 1'(b))) begin
            state_d[b] = close_s ? ST_FULL : ST_FILLING;
          end else begin
            state_d[b] = state_q[b];
          end
        end
        ST_FULL: begin
          if (release_s && (rd_bank_q == 1'(b))) begin
            state_d[b] = ST_EMPTY;
          end else begin
            state_d[b] = ST_FULL;
          end
        end
        default: state_d[b] = ST_EMPTY;
      endcase
    end

    if (close_s) begin
      cnt_d[wr_bank_q] = CNT_W'(wr_ptr_q) + CNT_W'(1'b1);
      wr_bank_d        = ~wr_bank_q;
      wr_ptr_d         = {PTR_W{1'b0}};
    end else if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Close and release never target the same bank: a FULL bank cannot be written.
    if (release_s) begin
      cnt_d[rd_bank_q] = {CNT_W{1'b0}};
      rd_bank_d        = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    // Decoded from next state so the flops line up with the bank they describe.
    in_ready_d  = (state_d[wr_bank_d] != ST_FULL);
    out_valid_d = (state_d[rd_bank_d] == ST_FULL);
    full_d      = (state_d[0] == ST_FULL) && (state_d[1] == ST_FULL);
    out_count_d = cnt_d[rd_bank_d];
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q[0]  <= ST_EMPTY;
      state_q[1]  <= ST_EMPTY;
      cnt_q[0]    <= {CNT_W{1'b0}};
      cnt_q[1]    <= {CNT_W{1'b0}};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      out_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
      out_count_q <= out_count_d;
    end
  end

  // Bank storage: released bank is zeroed so entries past out_count read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      if (release_s) begin
        mem_q[rd_bank_q] <= '0;
      end
      if (accept_s) begin
        mem_q[wr_bank_q][wr_ptr_q] <= bus_io.in_data;
      end
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.full      = full_q;
  assign bus_io.out_count = out_count_q;
  assign bus_io.out_data  = mem_q[rd_bank_q];

endmodule
